// File: rtl/rr_timeout_arbiter.sv
// rr_timeout_arbiter: round-robin output-port arbiter with per-input timeout timers.
// One instance sits per router output port, between input request logic and crossbar select.
//
// Ports:
//   clk      - clock, all state on rising edge
//   rst      - synchronous, active-high reset
//   req      - per-port level request [NPORTS]
//   flit_id  - per-port flit type, port i at [i*FID_W +: FID_W]
//   length   - per-port packet length, port i at [i*LEN_W +: LEN_W]
//   grant    - registered one-hot grant, all-zero when idle
//   idle     - registered, high when grant == 0
//   timeout  - registered one-cycle pulse for a port whose grant expired on its timer
//
// Optional feature macro: ARB_TAIL_RELEASE_EN
//   defined   : a TAIL_ID flit on the granted, requesting port ends the grant
//               (handled as a request drop, no timeout pulse)
//   undefined : flit_id only loads timeout limits on HEAD_ID
module rr_timeout_arbiter #(
  parameter int unsigned       NPORTS  = 5,
  parameter int unsigned       LEN_W   = 12,
  parameter int unsigned       FID_W   = 3,
  parameter logic [FID_W-1:0]  HEAD_ID = 3'b001,
  parameter logic [FID_W-1:0]  TAIL_ID = 3'b100
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NPORTS-1:0]         req,
  input  logic [NPORTS*FID_W-1:0]   flit_id,
  input  logic [NPORTS*LEN_W-1:0]   length,
  output logic [NPORTS-1:0]         grant,
  output logic                      idle,
  output logic [NPORTS-1:0]         timeout
);

  localparam int unsigned IDX_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

`ifdef ARB_TAIL_RELEASE_EN
  localparam bit TAIL_EN = 1'b1;
`else
  localparam bit TAIL_EN = 1'b0;
`endif

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t             state_q, state_d;
  // Index of the most recent grant; also the current holder while in ST_GRANT.
  logic [IDX_W-1:0]   last_q, last_d;
  logic [LEN_W-1:0]   count_q [NPORTS];
  logic [LEN_W-1:0]   count_d [NPORTS];
  logic [LEN_W-1:0]   limit_q [NPORTS];
  logic [NPORTS-1:0]  grant_d;
  logic [NPORTS-1:0]  timeout_d;

  logic               cur_req;
  logic               cur_tail;
  logic [LEN_W-1:0]   cur_count;
  logic [LEN_W-1:0]   cur_limit;
  logic [NPORTS-1:0]  cur_mask;
  logic [NPORTS-1:0]  req_eff;
  logic               held;
  logic               expired;

  // First asserted request searching k+1, k+2, ... wrapping, ending at k.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NPORTS-1:0] r,
                                               input logic [IDX_W-1:0]  k);
    logic [IDX_W-1:0] pick;
    logic             found;
    int unsigned      idx;
    pick  = k;
    found = 1'b0;
    for (int unsigned j = 1; j <= NPORTS; j++) begin
      idx = (32'(k) + j) % NPORTS;
      if (!found && r[IDX_W'(idx)]) begin
        pick  = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Timeout limit loads on any HEAD flit, regardless of grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NPORTS; i++) limit_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NPORTS; i++) begin
        if (flit_id[i*FID_W +: FID_W] == HEAD_ID) limit_q[i] <= length[i*LEN_W +: LEN_W];
      end
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= IDX_W'(NPORTS - 1);
      grant   <= '0;
      idle    <= 1'b1;
      timeout <= '0;
      for (int unsigned i = 0; i < NPORTS; i++) count_q[i] <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant   <= grant_d;
      idle    <= (grant_d == '0);
      timeout <= timeout_d;
      for (int unsigned i = 0; i < NPORTS; i++) count_q[i] <= count_d[i];
    end
  end

  // Holder view: request, tail, count and limit of the port at last_q.
  always_comb begin
    cur_req   = 1'b0;
    cur_tail  = 1'b0;
    cur_count = '0;
    cur_limit = '0;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      if (IDX_W'(i) == last_q) begin
        cur_req   = req[i];
        cur_tail  = TAIL_EN && req[i] && (flit_id[i*FID_W +: FID_W] == TAIL_ID);
        cur_count = count_q[i];
        cur_limit = limit_q[i];
      end
    end
    cur_mask = NPORTS'(1) << last_q;
    // A tail release behaves as if the holder had dropped its request.
    req_eff  = cur_tail ? (req & ~cur_mask) : req;
    held     = cur_req && !cur_tail && (cur_count < cur_limit);
    expired  = cur_req && !cur_tail && (cur_count >= cur_limit);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    timeout_d = '0;
    grant_d   = '0;
    for (int unsigned i = 0; i < NPORTS; i++) count_d[i] = '0;

    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_GRANT;
          last_d  = rr_pick(req, last_q);
        end
      end
      ST_GRANT: begin
        if (held) begin
          for (int unsigned i = 0; i < NPORTS; i++) begin
            if (IDX_W'(i) == last_q) count_d[i] = count_q[i] + LEN_W'(1);
          end
        end else begin
          timeout_d = expired ? cur_mask : '0;
          if (|req_eff) begin
            // Holder is re-picked only when it is the sole requester; its count restarts at 0.
            last_d = rr_pick(req_eff, last_q);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_GRANT) grant_d = NPORTS'(1) << last_d;
  end

endmodule

// File: tb/tb_rr_timeout_arbiter.sv
// Self-checking bench for rr_timeout_arbiter: directed scenarios plus randomized
// traffic compared against an integer-level behavioural model of the arbitration rules.
module tb_rr_timeout_arbiter;

  localparam int NP = 5;
  localparam int LW = 12;
  localparam int FW = 3;
  localparam logic [FW-1:0] HEAD = 3'b001;
  localparam logic [FW-1:0] TAIL = 3'b100;

`ifdef ARB_TAIL_RELEASE_EN
  localparam bit TAIL_ON = 1'b1;
`else
  localparam bit TAIL_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NP-1:0]     req = '0;
  logic [FW-1:0]     fid_a [NP];
  logic [LW-1:0]     len_a [NP];
  logic [NP*FW-1:0]  flit_id;
  logic [NP*LW-1:0]  length;
  logic [NP-1:0]     grant;
  logic              idle;
  logic [NP-1:0]     timeout;

  int checks = 0;
  int errors = 0;

  // Reference model state: holder -1 means idle.
  int            m_holder = -1;
  int            m_last   = NP - 1;
  int            m_count  = 0;
  int            m_limit [NP];
  logic [NP-1:0] m_grant   = '0;
  logic [NP-1:0] m_timeout = '0;
  logic          m_idle    = 1'b1;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NP; i++) begin
      flit_id[i*FW +: FW] = fid_a[i];
      length[i*LW +: LW]  = len_a[i];
    end
  end

  rr_timeout_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .flit_id (flit_id),
    .length  (length),
    .grant   (grant),
    .idle    (idle),
    .timeout (timeout)
  );

  function automatic bit bit_of(input logic [NP-1:0] v, input int p);
    logic [NP-1:0] s;
    s = v >> p;
    return s[0];
  endfunction

  // First requesting port after 'from' in circular order (from itself checked last).
  function automatic int rr_next(input int from, input logic [NP-1:0] r);
    int p;
    for (int s = 1; s <= NP; s++) begin
      p = (from + s) % NP;
      if (bit_of(r, p)) return p;
    end
    return -1;
  endfunction

  // Advance the model by one rising edge using the currently driven inputs.
  task automatic model_edge();
    logic [NP-1:0] r;
    int            nh;
    int            nc;
    int            h;
    logic [NP-1:0] nto;
    bit            tail;
    if (rst) begin
      m_holder = -1; m_last = NP - 1; m_count = 0;
      for (int p = 0; p < NP; p++) m_limit[p] = 0;
      m_grant = '0; m_timeout = '0; m_idle = 1'b1;
      return;
    end
    r = req; nh = m_holder; nc = 0; nto = '0; h = m_holder;
    if (h < 0) begin
      if (r != '0) nh = rr_next(m_last, r);
    end else begin
      tail = TAIL_ON && bit_of(r, h) && (fid_a[h] == TAIL);
      if (bit_of(r, h) && !tail && (m_count < m_limit[h])) begin
        nc = m_count + 1;
      end else begin
        if (bit_of(r, h) && !tail) nto = NP'(1) << h;
        if (tail) r = r & ~(NP'(1) << h);
        nh = (r != '0) ? rr_next(h, r) : -1;
      end
    end
    for (int p = 0; p < NP; p++) if (fid_a[p] == HEAD) m_limit[p] = int'(len_a[p]);
    m_holder  = nh;
    if (nh >= 0) m_last = nh;
    m_count   = nc;
    m_grant   = (nh >= 0) ? (NP'(1) << nh) : '0;
    m_idle    = (nh < 0);
    m_timeout = nto;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_flits();
    for (int p = 0; p < NP; p++) begin
      fid_a[p] = '0;
      len_a[p] = '0;
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1; req = '0; clear_flits();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 5'b11111; clear_flits();
    tick(); tick();
    checks++; if (grant !== 5'b00000) begin errors++; $display("FAIL reset_grant got=%b exp=00000", grant); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got=%b exp=1", idle); end
    checks++; if (timeout !== 5'b00000) begin errors++; $display("FAIL reset_timeout got=%b exp=00000", timeout); end
    rst = 1'b0;
    tick();
    checks++; if (grant !== 5'b00001) begin errors++; $display("FAIL reset_release_grant got=%b exp=00001", grant); end
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL reset_release_idle got=%b exp=0", idle); end
  endtask

  task automatic test_timeout();
    reset_dut();
    fid_a[0] = HEAD; len_a[0] = 12'd3; req = 5'b00101;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) fid_a[0] = '0;
      checks++; if (grant !== 5'b00001) begin errors++; $display("FAIL timeout_hold cyc=%0d got=%b exp=00001", k, grant); end
    end
    tick();
    checks++; if (grant !== 5'b00100) begin errors++; $display("FAIL timeout_handover got=%b exp=00100", grant); end
    checks++; if (timeout !== 5'b00001) begin errors++; $display("FAIL timeout_pulse got=%b exp=00001", timeout); end
    tick();
    checks++; if (timeout[0] !== 1'b0) begin errors++; $display("FAIL timeout_one_cycle got=%b exp=0", timeout[0]); end
  endtask

  task automatic test_round_robin();
    int seq [6] = '{0, 1, 2, 3, 4, 0};
    logic [NP-1:0] exp_g;
    reset_dut();
    req = 5'b11111;
    for (int k = 0; k < 6; k++) begin
      tick();
      exp_g = NP'(1) << seq[k];
      checks++; if (grant !== exp_g) begin errors++; $display("FAIL rr_seq step=%0d got=%b exp=%b", k, grant, exp_g); end
      checks++; if (idle !== 1'b0) begin errors++; $display("FAIL rr_no_bubble step=%0d got=%b exp=0", k, idle); end
    end
  endtask

  task automatic test_early_drop();
    reset_dut();
    fid_a[3] = HEAD; len_a[3] = 12'd10; req = 5'b01000;
    tick();
    fid_a[3] = '0;
    checks++; if (grant !== 5'b01000) begin errors++; $display("FAIL drop_grant got=%b exp=01000", grant); end
    tick();
    req = '0;
    tick();
    checks++; if (grant !== 5'b00000) begin errors++; $display("FAIL drop_release got=%b exp=00000", grant); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL drop_idle got=%b exp=1", idle); end
    checks++; if (timeout !== 5'b00000) begin errors++; $display("FAIL drop_no_timeout got=%b exp=00000", timeout); end
  endtask

  task automatic test_sole_requester();
    logic [NP-1:0] exp_t;
    reset_dut();
    fid_a[1] = HEAD; len_a[1] = 12'd1; req = 5'b00010;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) fid_a[1] = '0;
      exp_t = (k >= 3 && (k % 2) == 1) ? 5'b00010 : 5'b00000;
      checks++; if (grant !== 5'b00010) begin errors++; $display("FAIL sole_grant cyc=%0d got=%b exp=00010", k, grant); end
      checks++; if (timeout !== exp_t) begin errors++; $display("FAIL sole_timeout cyc=%0d got=%b exp=%b", k, timeout, exp_t); end
    end
  endtask

  task automatic test_limit_lower();
    reset_dut();
    fid_a[2] = HEAD; len_a[2] = 12'd8; req = 5'b00100;
    tick();
    fid_a[2] = '0; req = 5'b01100;
    tick(); tick(); tick();
    // Count is 3 here; new limit lands as count reaches 4.
    fid_a[2] = HEAD; len_a[2] = 12'd1;
    tick();
    fid_a[2] = '0;
    checks++; if (grant !== 5'b00100) begin errors++; $display("FAIL lower_still_held got=%b exp=00100", grant); end
    tick();
    checks++; if (grant !== 5'b01000) begin errors++; $display("FAIL lower_release got=%b exp=01000", grant); end
    checks++; if (timeout !== 5'b00100) begin errors++; $display("FAIL lower_timeout got=%b exp=00100", timeout); end
  endtask

  task automatic test_rst_mid_grant();
    reset_dut();
    fid_a[0] = HEAD; len_a[0] = 12'd10; req = 5'b00001;
    tick(); tick();
    rst = 1'b1;
    tick();
    checks++; if (grant !== 5'b00000) begin errors++; $display("FAIL rstmid_grant got=%b exp=00000", grant); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rstmid_idle got=%b exp=1", idle); end
    rst = 1'b0; fid_a[0] = '0;
    tick();
    checks++; if (grant !== 5'b00001) begin errors++; $display("FAIL rstmid_regrant got=%b exp=00001", grant); end
    tick();
    // Limit was cleared by reset, so the sole requester expires after one cycle.
    checks++; if (timeout !== 5'b00001) begin errors++; $display("FAIL rstmid_limit_cleared got=%b exp=00001", timeout); end
  endtask

  task automatic test_tail();
    logic [NP-1:0] exp_g;
    reset_dut();
    fid_a[4] = HEAD; len_a[4] = 12'd20; req = 5'b10000;
    tick();
    fid_a[4] = '0;
    checks++; if (grant !== 5'b10000) begin errors++; $display("FAIL tail_grant got=%b exp=10000", grant); end
    tick(); tick();
    fid_a[4] = TAIL;
    tick();
    fid_a[4] = '0;
    exp_g = TAIL_ON ? 5'b00000 : 5'b10000;
    checks++; if (grant !== exp_g) begin errors++; $display("FAIL tail_release got=%b exp=%b", grant, exp_g); end
    checks++; if (timeout !== 5'b00000) begin errors++; $display("FAIL tail_no_timeout got=%b exp=00000", timeout); end
  endtask

  task automatic test_random();
    int sel;
    reset_dut();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 127) == 0);
      if ($urandom_range(0, 2) == 0) req = NP'($urandom);
      for (int p = 0; p < NP; p++) begin
        sel = $urandom_range(0, 9);
        fid_a[p] = (sel == 9) ? TAIL : (sel >= 7) ? HEAD : FW'($urandom_range(0, 1) * 2);
        len_a[p] = LW'($urandom_range(0, 6));
      end
      tick();
      checks++; if (grant !== m_grant) begin errors++; $display("FAIL rand_grant cyc=%0d got=%b exp=%b", c, grant, m_grant); end
      checks++; if (idle !== m_idle) begin errors++; $display("FAIL rand_idle cyc=%0d got=%b exp=%b", c, idle, m_idle); end
      checks++; if (timeout !== m_timeout) begin errors++; $display("FAIL rand_timeout cyc=%0d got=%b exp=%b", c, timeout, m_timeout); end
    end
    rst = 1'b0; req = '0; clear_flits();
  endtask

  initial begin
    clear_flits();
    for (int p = 0; p < NP; p++) m_limit[p] = 0;
    test_reset();
    test_timeout();
    test_round_robin();
    test_early_drop();
    test_sole_requester();
    test_limit_lower();
    test_rst_mid_grant();
    test_tail();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
